// File: rtl/broadcast_sequencer.sv
// Purpose: sequences one (port, line, word) request onto the 4x4 serial broadcaster: selects, settle, MSB-first shift. Optional parity: BCAST_PARITY_EN.
// Latency: selects after accept edge N, first bit after N+SETTLE, done after N+SETTLE+NBITS, ready again one cycle later.
// Backpressure: reqReady is high only in IDLE; a held reqValid is accepted on the first idle edge, nothing is dropped.
module broadcast_sequencer #(
    parameter int DATA_W = 8,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [1:0]        reqPort,
    input  logic [1:0]        reqLine,
    input  logic [DATA_W-1:0] reqData,
    output logic              done,
    output logic              busy,
    output logic              serIn,
    output logic [3:0]        PB,
    output logic [0:1]        LB0,
    output logic [0:1]        LB1,
    output logic [0:1]        LB2,
    output logic [0:1]        LB3
);

`ifdef BCAST_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GUARD} state_t;

    state_t           state_q, state_n;
    logic [3:0]       settle_q, settle_n;
    logic [BW-1:0]    bits_q, bits_n;
    logic [NBITS-1:0] frame_q, frame_n;
    logic [1:0]       port_q, port_n;
    logic [1:0]       line_q, line_n;
    logic             sel_n;
    logic [0:1]       code_n;

    always_comb begin
        state_n  = state_q;
        settle_n = settle_q;
        bits_n   = bits_q;
        frame_n  = frame_q;
        port_n   = port_q;
        line_n   = line_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    state_n  = SETUP;
                    settle_n = 4'(SETTLE - 1);
                    port_n   = reqPort;
                    line_n   = reqLine;
`ifdef BCAST_PARITY_EN
                    frame_n  = {reqData, ^reqData};
`else
                    frame_n  = reqData;
`endif
                end
            end
            SETUP: begin
                if (settle_q == 4'd0) begin
                    state_n = SHIFT;
                    bits_n  = BW'(NBITS - 1);
                end else begin
                    settle_n = settle_q - 4'd1;
                end
            end
            SHIFT: begin
                if (bits_q == '0) begin
                    state_n = GUARD;
                end else begin
                    bits_n  = bits_q - 1'b1;
                    frame_n = frame_q << 1;
                end
            end
            GUARD: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are registered from next-state values so they change exactly at the edge.
        sel_n  = (state_n != IDLE);
        code_n = {line_n[1], line_n[1] ^ line_n[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            bits_q   <= '0;
            frame_q  <= '0;
            port_q   <= '0;
            line_q   <= '0;
            reqReady <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            serIn    <= 1'b0;
            PB       <= 4'b0000;
            LB0      <= 2'b00;
            LB1      <= 2'b00;
            LB2      <= 2'b00;
            LB3      <= 2'b00;
        end else begin
            state_q  <= state_n;
            settle_q <= settle_n;
            bits_q   <= bits_n;
            frame_q  <= frame_n;
            port_q   <= port_n;
            line_q   <= line_n;
            reqReady <= (state_n == IDLE);
            busy     <= (state_n != IDLE);
            done     <= (state_n == GUARD);
            serIn    <= (state_n == SHIFT) & frame_n[NBITS-1];
            PB       <= sel_n ? (4'b0001 << port_n) : 4'b0000;
            LB0      <= (sel_n && port_n == 2'd0) ? code_n : 2'b00;
            LB1      <= (sel_n && port_n == 2'd1) ? code_n : 2'b00;
            LB2      <= (sel_n && port_n == 2'd2) ? code_n : 2'b00;
            LB3      <= (sel_n && port_n == 2'd3) ? code_n : 2'b00;
        end
    end

endmodule

// File: tb/tb_broadcast_sequencer.sv
// Randomized and directed bench for broadcast_sequencer, checked every cycle against a timeline model.
module tb_broadcast_sequencer;
    localparam int DW = 8;
    localparam int S  = 2;
`ifdef BCAST_PARITY_EN
    localparam int NB = DW + 1;
    localparam int DONE_K = 12;
`else
    localparam int NB = DW;
    localparam int DONE_K = 11;
`endif

    logic          clk;
    logic          rst_n;
    logic          reqValid;
    logic          reqReady;
    logic [1:0]    reqPort;
    logic [1:0]    reqLine;
    logic [DW-1:0] reqData;
    logic          done;
    logic          busy;
    logic          serIn;
    logic [3:0]    PB;
    logic [0:1]    LB0, LB1, LB2, LB3;

    broadcast_sequencer #(.DATA_W(DW), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
        .reqPort(reqPort), .reqLine(reqLine), .reqData(reqData),
        .done(done), .busy(busy), .serIn(serIn), .PB(PB),
        .LB0(LB0), .LB1(LB1), .LB2(LB2), .LB3(LB3)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] frame(input logic [DW-1:0] d);
`ifdef BCAST_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    logic [1:0] lut [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Timeline model: m_k counts cycles since the accepting edge (1 = first SETUP cycle).
    bit            m_act = 1'b0;
    int            m_k = 0;
    logic [1:0]    m_port, m_line;
    logic [DW-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (reqValid) begin
                m_act  = 1'b1;
                m_k    = 1;
                m_port = reqPort;
                m_line = reqLine;
                m_data = reqData;
            end
        end else begin
            m_k++;
            if (m_k > S + NB + 1) m_act = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [3:0]    e_pb;
        logic [7:0]    e_lb;
        logic          e_ser;
        logic [NB-1:0] fr;
        e_pb  = 4'b0000;
        e_lb  = 8'h00;
        e_ser = 1'b0;
        if (m_act) begin
            e_pb = 4'b0001 << m_port;
            e_lb = 8'(lut[m_line]) << (6 - 2 * int'(m_port));
            if (m_k >= S + 1 && m_k <= S + NB) begin
                fr    = frame(m_data);
                e_ser = fr[NB - 1 - (m_k - S - 1)];
            end
        end
        chk("ready", reqReady, !m_act);
        chk("busy", busy, m_act);
        chk("done", done, m_act && m_k == S + NB + 1);
        chk("serIn", serIn, e_ser);
        chk("PB", PB, e_pb);
        chk("LB", {LB0, LB1, LB2, LB3}, e_lb);
    end

    // Called on a falling edge; returns on the falling edge where done is seen.
    task automatic xfer(input logic [1:0] p, input logic [1:0] l, input logic [DW-1:0] d,
                        input bit hold, output int dk, output logic [3:0] pb1,
                        output logic [7:0] lb1, output logic [NB-1:0] word);
        int g;
        reqValid = 1'b1;
        reqPort  = p;
        reqLine  = l;
        reqData  = d;
        g = 0;
        while (!reqReady && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("accept_wait", g < 50, 1);
        @(posedge clk);
        #2;
        if (hold) begin
            reqPort = 2'd1;
            reqLine = 2'($urandom_range(0, 3));
            reqData = DW'($urandom);
        end else begin
            reqValid = 1'b0;
            reqData  = ~d;
            reqPort  = ~p;
        end
        dk = 0; word = '0; pb1 = '0; lb1 = '0;
        do begin
            @(negedge clk);
            dk++;
            if (dk == 1) begin
                pb1 = PB;
                lb1 = {LB0, LB1, LB2, LB3};
            end
            if (dk >= S + 1 && dk <= S + NB) word = {word[NB-2:0], serIn};
            if (hold && dk == S + 2) reqData = ~reqData;
        end while (!done && dk < 100);
    endtask

    initial begin
        int            dk;
        logic [3:0]    pb1;
        logic [7:0]    lb1;
        logic [NB-1:0] word;
        logic [DW-1:0] d;
        logic [7:0]    sweep_exp [4];
        sweep_exp = '{8'h00, 8'h40, 8'hC0, 8'h80};

        rst_n = 1'b0; reqValid = 1'b0; reqPort = 2'd0; reqLine = 2'd0; reqData = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", reqReady, 1);
        chk("rst_pb", PB, 0);

        xfer(2'd2, 2'd2, 8'hA5, 1'b0, dk, pb1, lb1, word);
        chk("a5_pb", pb1, 4'b0100);
        chk("a5_lb2", lb1[3:2], 2'b11);
        chk("a5_bits", word >> (NB - DW), 8'hA5);
        chk("a5_done_k", dk, DONE_K);
        @(negedge clk);
        chk("a5_pb_after", PB, 4'b0000);

        for (int l = 0; l < 4; l++) begin
            xfer(2'd0, l[1:0], DW'($urandom), 1'b0, dk, pb1, lb1, word);
            chk($sformatf("sweep_lb_line%0d", l), lb1, sweep_exp[l]);
        end

        xfer(2'd3, 2'd1, 8'h96, 1'b1, dk, pb1, lb1, word);
        chk("busy_first_bits", word >> (NB - DW), 8'h96);
        xfer(2'd1, 2'd0, 8'h3C, 1'b0, dk, pb1, lb1, word);
        chk("busy_second_pb", pb1, 4'b0010);
        chk("busy_second_bits", word >> (NB - DW), 8'h3C);

        xfer(2'd0, 2'd3, 8'h07, 1'b0, dk, pb1, lb1, word);
        chk("x07_bits", word >> (NB - DW), 8'h07);
        chk("x07_done_k", dk, DONE_K);
`ifdef BCAST_PARITY_EN
        chk("x07_parity", word[0], 1);
`endif

        repeat (20) begin
            d = DW'($urandom);
            xfer(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), d,
                 1'($urandom_range(0, 1)), dk, pb1, lb1, word);
            chk("rnd_word", word, frame(d));
            chk("rnd_done_k", dk, DONE_K);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Abort during the 4th data bit of an all-ones word.
        reqValid = 1'b0;
        @(negedge clk);
        reqValid = 1'b1; reqPort = 2'd1; reqLine = 2'd3; reqData = 8'hFF;
        @(posedge clk);
        #2 reqValid = 1'b0;
        repeat (S + 3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_pb", PB, 4'b0000);
        chk("abort_ser", serIn, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        xfer(2'd2, 2'd1, 8'h5A, 1'b0, dk, pb1, lb1, word);
        chk("recover_bits", word >> (NB - DW), 8'h5A);
        chk("recover_lb2", lb1[3:2], 2'b01);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
